// File: rtl/caliptra_prim_sec_arb_pkg.sv
// rtl/caliptra_prim_sec_arb_pkg.sv - state encodings and legality check for the hardened rr arbiter
package caliptra_prim_sec_arb_pkg;

  localparam int StateW = 5;

  // Pairwise Hamming distance >= 3 so a single upset can never land on another legal code.
  localparam logic [StateW-1:0] IdleEnc  = 5'b01101;
  localparam logic [StateW-1:0] BusyEnc  = 5'b10011;
  localparam logic [StateW-1:0] ErrorEnc = 5'b11110;

  typedef enum logic [StateW-1:0] {
    StIdle  = IdleEnc,
    StBusy  = BusyEnc,
    StError = ErrorEnc
  } arb_state_e;

  function automatic logic state_is_legal(input logic [StateW-1:0] s);
    return (s == StIdle) || (s == StBusy) || (s == StError);
  endfunction

endpackage

// File: rtl/caliptra_prim_rr_pick.sv
// rtl/caliptra_prim_rr_pick.sv - first set request scanning upward from a rotating pointer
module caliptra_prim_rr_pick #(
  parameter int N    = 4,
  parameter int IdxW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic [IdxW-1:0] idx,
  output logic [N-1:0]    onehot,
  output logic            any
);

  int k;

  always_comb begin
    idx = '0;
    k   = 0;
    any = |req;
    // Walk offsets from farthest to nearest so the nearest set bit is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      k = int'(ptr) + i;
      if (k >= N) k = k - N;
      if (req[k]) idx = k[IdxW-1:0];
    end
    onehot = any ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/caliptra_prim_sec_anchor_buf.sv
// rtl/caliptra_prim_sec_anchor_buf.sv - opaque buffer that keeps hardened flops from being merged
module caliptra_prim_sec_anchor_buf #(
  parameter int Width = 1
) (
  input  logic [Width-1:0] in_i,
  output logic [Width-1:0] out_o
);

  assign out_o = in_i;

endmodule

// File: rtl/caliptra_prim_sec_rr_arb.sv
// rtl/caliptra_prim_sec_rr_arb.sv - hardened round-robin arbiter with sparse FSM and sticky fault
module caliptra_prim_sec_rr_arb
  import caliptra_prim_sec_arb_pkg::*;
#(
  parameter int N    = 4,
  parameter int DW   = 32,
  parameter int IdxW = $clog2(N)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [N-1:0]    req_i,
  input  logic [N*DW-1:0] data_i,
  output logic [N-1:0]    gnt_o,
  output logic            valid_o,
  output logic [DW-1:0]   data_o,
  output logic [IdxW-1:0] idx_o,
  input  logic            ready_i,
  output logic            err_o
);

  localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

  logic [StateW-1:0] state_raw_q;
  logic [StateW-1:0] state_q;
  logic [IdxW-1:0]   rr_ptr_q;
  logic [IdxW-1:0]   winner_q;
  logic [N-1:0]      winner_oh_q;

  logic [IdxW-1:0]   pick_idx;
  logic [N-1:0]      pick_oh;
  logic              pick_any;
  logic              fault;
  logic              busy;

  caliptra_prim_sec_anchor_buf #(
    .Width(StateW)
  ) u_state_anchor (
    .in_i (state_raw_q),
    .out_o(state_q)
  );

  caliptra_prim_rr_pick #(
    .N   (N),
    .IdxW(IdxW)
  ) u_pick (
    .req   (req_i),
    .ptr   (rr_ptr_q),
    .idx   (pick_idx),
    .onehot(pick_oh),
    .any   (pick_any)
  );

  assign fault = !state_is_legal(state_q) ||
                 ((state_q == StBusy) && (winner_oh_q != (N'(1) << winner_q)));

  // A detected fault masks the Busy outputs in the same cycle it is seen.
  assign busy    = (state_q == StBusy) && !fault;
  assign valid_o = busy;
  assign idx_o   = busy ? winner_q : '0;
  assign data_o  = busy ? data_i[int'(winner_q)*DW +: DW] : '0;
  assign gnt_o   = (busy && ready_i) ? winner_oh_q : '0;
  assign err_o   = fault || (state_q == StError);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_raw_q <= StIdle;
      rr_ptr_q    <= '0;
      winner_q    <= '0;
      winner_oh_q <= '0;
    end else if (fault) begin
      state_raw_q <= StError;
    end else begin
      case (state_q)
        StIdle: begin
          if (pick_any) begin
            winner_q    <= pick_idx;
            winner_oh_q <= pick_oh;
            state_raw_q <= StBusy;
          end
        end
        StBusy: begin
          if (ready_i) begin
            rr_ptr_q    <= (winner_q == LastIdx) ? '0 : winner_q + IdxW'(1);
            state_raw_q <= StIdle;
          end else if (!req_i[winner_q]) begin
            state_raw_q <= StIdle;
          end
        end
        StError: state_raw_q <= StError;
        default: state_raw_q <= StError;
      endcase
    end
  end

endmodule

// File: tb/tb_caliptra_prim_sec_rr_arb.sv
// tb/tb_caliptra_prim_sec_rr_arb.sv - self-checking bench for caliptra_prim_sec_rr_arb
module tb_caliptra_prim_sec_rr_arb;

  localparam int N    = 4;
  localparam int DW   = 32;
  localparam int IdxW = $clog2(N);
  localparam int OW   = N + 1 + IdxW + DW + 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*DW-1:0] data;
  logic            ready;
  logic [N-1:0]    gnt;
  logic            valid;
  logic [DW-1:0]   dout;
  logic [IdxW-1:0] idx;
  logic            err;
  logic [OW-1:0]   obs;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: transaction-level view of the arbiter.
  bit m_busy, m_err;
  int m_ptr, m_win;

  always #5 clk = ~clk;

  caliptra_prim_sec_rr_arb #(.N(N), .DW(DW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .req_i  (req),
    .data_i (data),
    .gnt_o  (gnt),
    .valid_o(valid),
    .data_o (dout),
    .idx_o  (idx),
    .ready_i(ready),
    .err_o  (err)
  );

  assign obs = {gnt, valid, idx, dout, err};

  function automatic logic [OW-1:0] m_out();
    logic [N-1:0]    g;
    logic            v;
    logic [IdxW-1:0] ix;
    logic [DW-1:0]   d;
    g = '0; v = 1'b0; ix = '0; d = '0;
    if (!m_err && m_busy) begin
      v  = 1'b1;
      ix = m_win[IdxW-1:0];
      d  = data[m_win*DW +: DW];
      if (ready) g = N'(1) << m_win;
    end
    return {g, v, ix, d, m_err};
  endfunction

  function automatic int m_pick();
    for (int o = 0; o < N; o++)
      if (req[(m_ptr + o) % N]) return (m_ptr + o) % N;
    return -1;
  endfunction

  task automatic drive(input logic rn, input logic [N-1:0] r, input logic rdy);
    @(negedge clk);
    rst_n = rn;
    req   = r;
    ready = rdy;
    #1;
  endtask

  task automatic tick();
    int p;
    @(posedge clk);
    if (!rst_n) begin
      m_busy = 0; m_err = 0; m_ptr = 0; m_win = 0;
    end else if (!m_err) begin
      if (!m_busy) begin
        p = m_pick();
        if (p >= 0) begin m_win = p; m_busy = 1; end
      end else if (ready) begin
        m_ptr  = (m_win + 1) % N;
        m_busy = 0;
      end else if (!req[m_win]) begin
        m_busy = 0;
      end
    end
  endtask

  task automatic do_reset();
    drive(1'b0, '0, 1'b0);
    tick();
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, '0, 1'b0);
      if (c > 0) begin
        n_vec++;
        if (obs !== '0) begin n_err++; $display("FAIL reset_hold c%0d obs=%h exp=0", c, obs); end
      end
      tick();
    end
    drive(1'b1, '0, 1'b0);
    n_vec++;
    if (obs !== '0) begin n_err++; $display("FAIL reset_out obs=%h exp=0", obs); end
    n_vec++;
    if (dut.state_q !== 5'b01101) begin n_err++; $display("FAIL reset_state obs=%b exp=01101", dut.state_q); end
    tick();
  endtask

  task automatic test_single();
    logic [OW-1:0] want;
    data[2*DW +: DW] = 32'hA5A5_0002;
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, (c < 2) ? 4'b0100 : 4'b0000, 1'b1);
      want = (c == 1) ? {4'b0100, 1'b1, 2'd2, 32'hA5A5_0002, 1'b0} : '0;
      n_vec++;
      if (obs !== want || obs !== m_out()) begin
        n_err++; $display("FAIL single c%0d obs=%h exp=%h model=%h", c, obs, want, m_out());
      end
      tick();
    end
  endtask

  task automatic test_fairness();
    logic [N-1:0] want;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      drive(1'b1, 4'b1111, 1'b1);
      want = (c % 2 == 1) ? (N'(1) << ((c / 2) % N)) : '0;
      n_vec++;
      if (gnt !== want || obs !== m_out()) begin
        n_err++; $display("FAIL fair c%0d gnt=%b exp=%b obs=%h model=%h", c, gnt, want, obs, m_out());
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 4'b0011, 1'b0);
      n_vec++;
      if ((c > 0 && {valid, idx, gnt} !== {1'b1, 2'd0, 4'b0000}) || obs !== m_out()) begin
        n_err++; $display("FAIL bp_hold c%0d obs=%h model=%h", c, obs, m_out());
      end
      tick();
    end
    drive(1'b1, 4'b0010, 1'b0);
    n_vec++;
    if (gnt !== '0 || obs !== m_out()) begin n_err++; $display("FAIL bp_drop obs=%h model=%h", obs, m_out()); end
    tick();
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 4'b0011, 1'b1);
      n_vec++;
      if (gnt !== ((c == 1) ? 4'b0001 : 4'b0000) || obs !== m_out()) begin
        n_err++; $display("FAIL bp_repick c%0d gnt=%b obs=%h model=%h", c, gnt, obs, m_out());
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 4'b1000, 1'b0);
      tick();
    end
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, 4'b1000, 1'b0);
      n_vec++;
      if (gnt !== '0) begin n_err++; $display("FAIL midbusy_rst c%0d gnt=%b exp=0", c, gnt); end
      tick();
    end
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 4'b1001, 1'b1);
      n_vec++;
      if (gnt !== ((c == 1) ? 4'b0001 : 4'b0000) || obs !== m_out()) begin
        n_err++; $display("FAIL midbusy_after c%0d gnt=%b obs=%h model=%h", c, gnt, obs, m_out());
      end
      tick();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < N; k++) data[k*DW +: DW] = $urandom;
      drive(($urandom_range(0, 49) != 0), N'($urandom), 1'($urandom));
      n_vec++;
      if (obs !== m_out()) begin n_err++; $display("FAIL random c%0d obs=%h model=%h", c, obs, m_out()); end
      tick();
    end
  endtask

  task automatic test_fault_state();
    do_reset();
    drive(1'b1, 4'b1111, 1'b0);
    tick();
    drive(1'b1, 4'b1111, 1'b0);
    force dut.state_q = 5'b00000;
    #1;
    m_err = 1;
    n_vec++;
    if ({err, valid, gnt} !== {1'b1, 1'b0, 4'b0000}) begin
      n_err++; $display("FAIL fstate_same err=%b valid=%b gnt=%b exp=1/0/0", err, valid, gnt);
    end
    tick();
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 4'b1111, 1'b1);
      if (c == 0) release dut.state_q;
      #1;
      n_vec++;
      if (obs !== m_out() || err !== 1'b1) begin n_err++; $display("FAIL fstate_stick c%0d obs=%h model=%h", c, obs, m_out()); end
      tick();
    end
    do_reset();
    drive(1'b1, '0, 1'b0);
    n_vec++;
    if (err !== 1'b0 || obs !== m_out()) begin n_err++; $display("FAIL fstate_clear err=%b exp=0", err); end
    tick();
  endtask

  task automatic test_fault_onehot();
    do_reset();
    drive(1'b1, 4'b0100, 1'b0);
    tick();
    drive(1'b1, 4'b0100, 1'b0);
    force dut.winner_oh_q = 4'b0001;
    #1;
    m_err = 1;
    n_vec++;
    if ({err, valid, gnt} !== {1'b1, 1'b0, 4'b0000}) begin
      n_err++; $display("FAIL foh_same err=%b valid=%b gnt=%b exp=1/0/0", err, valid, gnt);
    end
    tick();
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 4'b0100, 1'b1);
      if (c == 0) release dut.winner_oh_q;
      #1;
      n_vec++;
      if (obs !== m_out() || err !== 1'b1) begin n_err++; $display("FAIL foh_stick c%0d obs=%h model=%h", c, obs, m_out()); end
      tick();
    end
    do_reset();
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 4'b0100, 1'b1);
      n_vec++;
      if (err !== 1'b0 || obs !== m_out()) begin n_err++; $display("FAIL foh_clear c%0d obs=%h model=%h", c, obs, m_out()); end
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    data  = '0;
    ready = 1'b0;
    m_busy = 0; m_err = 0; m_ptr = 0; m_win = 0;
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_reset_mid_busy();
    test_random();
    test_fault_state();
    test_fault_onehot();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
